parity_checker: RTL

PARITY_CHECKER -- requirements
Module: parity_checker

---
 rtl/parity_checker_pkg.sv | 5 +
 rtl/parity_checker_if.sv | 14 +
 rtl/parity_checker_sat_counter.sv | 14 +
 rtl/parity_checker.sv | 66 ++++++
 4 files changed

// File: rtl/parity_checker_pkg.sv
// parity_checker_pkg: shared FSM state encoding and error-counter width
package parity_checker_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;
  localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/parity_checker_if.sv
// parity_checker_if: serial bit input and frame result bus
interface parity_checker_if #(parameter int DATA_W = 3);
  import parity_checker_pkg::*;
  logic i_x;
  logic i_valid;
  logic i_clr;
  logic [DATA_W-1:0] o_data;
  logic o_done;
  logic o_err;
  logic o_busy;
  logic [ERR_CNT_W-1:0] o_err_cnt;
  modport master (output i_x, i_valid, i_clr, input o_data, o_done, o_err, o_busy, o_err_cnt);
  modport slave (input i_x, i_valid, i_clr, output o_data, o_done, o_err, o_busy, o_err_cnt);
endinterface

// File: rtl/parity_checker_sat_counter.sv
// sat_counter: saturating incrementer with synchronous active-low reset
module sat_counter
  import parity_checker_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_inc,
  output logic [ERR_CNT_W-1:0] o_cnt
);
  always_ff @(posedge i_clk) begin
    if (!i_rst) o_cnt <= '0;
    else if (i_inc && o_cnt != '1) o_cnt <= o_cnt + 1'b1;
  end
endmodule

// File: rtl/parity_checker.sv
// parity_checker: LSB-first serial frame receiver with parity check and error count
module parity_checker
  import parity_checker_pkg::*;
#(
  parameter int   DATA_W = 3,
  parameter logic ODD    = 1'b0
) (
  input logic            i_clk,
  input logic            i_rst,
  parity_checker_if.slave bus
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] sh;
  logic rx, acc, start, mis, last;
  assign acc   = bus.i_valid && !bus.i_clr;
  assign start = state == IDLE || state == DONE;
  assign mis   = rx ^ bus.i_x ^ ODD;
  assign last  = idx == IW'(DATA_W - 1);
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    if (bus.i_clr) nxt = IDLE;
    else if (start) nxt = !bus.i_valid ? IDLE : (DATA_W == 1 ? PARITY : DATA);
    else if (state == DATA) nxt = bus.i_valid && last ? PARITY : DATA;
    else nxt = bus.i_valid ? DONE : PARITY;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      idx        <= '0;
      rx         <= 1'b0;
      sh         <= '0;
      bus.o_data <= '0;
      bus.o_err  <= 1'b0;
    end else if (bus.i_clr) begin
      idx <= '0;
      rx  <= 1'b0;
    end else if (bus.i_valid) begin
      if (start) begin
        sh  <= DATA_W'(bus.i_x);
        idx <= IW'(1);
        rx  <= bus.i_x;
      end else if (state == DATA) begin
        sh[idx] <= bus.i_x;
        idx     <= idx + 1'b1;
        rx      <= rx ^ bus.i_x;
      end else if (state == PARITY) begin
        bus.o_data <= sh;
        bus.o_err  <= mis;
        idx        <= '0;
      end
    end
  end
  assign bus.o_done = state == DONE;
  assign bus.o_busy = state == DATA || state == PARITY;
  sat_counter u_err_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (state == PARITY && acc && mis),
    .o_cnt (bus.o_err_cnt)
  );
endmodule
